// File: rtl/wash_cycle_timer.sv
// Wash cycle timer: follows the washer phase sequence, times the wash and spin
// periods and watchdogs fill/drain. The program select port is program_sel
// because "program" is a reserved word in SystemVerilog.
module wash_cycle_timer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [1:0]        program_sel,
  input  logic              fill_value_on,
  input  logic              motor_on,
  input  logic              drain_value_on,
  input  logic              drained,
  input  logic              done,
  input  logic              pause,
  input  logic              fault_clear,
  output logic              cycle_timeout,
  output logic              spin_timeout,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] remaining,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [DATA_W-1:0] FILL_TICKS  = DATA_W'(30);
  localparam logic [DATA_W-1:0] DRAIN_TICKS = DATA_W'(20);
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_FILL  = 2'b01;
  localparam logic [1:0] CODE_DRAIN = 2'b10;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic [1:0]        prog_q, prog_d;
  logic [1:0]        code_q, code_d;
  logic              dec_en;
  logic              expired;
  logic [DATA_W-1:0] cnt_dec;

  function automatic logic [DATA_W-1:0] wash_ticks(input logic [1:0] p);
    case (p)
      2'b00:   return DATA_W'(8);
      2'b01:   return DATA_W'(20);
      2'b10:   return DATA_W'(40);
      default: return DATA_W'(12);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] spin_ticks(input logic [1:0] p);
    case (p)
      2'b00:   return DATA_W'(4);
      2'b01:   return DATA_W'(10);
      2'b10:   return DATA_W'(16);
      default: return DATA_W'(2);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      prog_q  <= 2'b00;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      prog_q  <= prog_d;
      code_q  <= code_d;
    end
  end

  // Pause freezes both the decrement and watchdog expiry; transitions still
  // fire and reload, and a reload always wins over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    prog_d  = prog_q;
    code_d  = code_q;
    dec_en  = tick && !pause && (cnt_q != '0);
    expired = !pause && (cnt_q == '0);
    cnt_dec = cnt_q - DATA_W'(1);
    case (state_q)
      S_IDLE: begin
        if (fill_value_on) begin
          state_d = S_FILL;
          cnt_d   = FILL_TICKS;
          prog_d  = program_sel;
        end
      end
      S_FILL: begin
        if (motor_on) begin
          state_d = S_WASH;
          cnt_d   = wash_ticks(prog_q);
        end else if (expired) begin
          state_d = S_FAULT;
          code_d  = CODE_FILL;
        end else if (dec_en) begin
          cnt_d = cnt_dec;
        end
      end
      S_WASH: begin
        if (drain_value_on) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_TICKS;
        end else if (dec_en) begin
          cnt_d = cnt_dec;
        end
      end
      S_DRAIN: begin
        if (!pass_q && fill_value_on) begin
          state_d = S_FILL;
          cnt_d   = FILL_TICKS;
          pass_d  = 1'b1;
        end else if (pass_q && drained) begin
          state_d = S_SPIN;
          cnt_d   = spin_ticks(prog_q);
        end else if (expired) begin
          state_d = S_FAULT;
          code_d  = CODE_DRAIN;
        end else if (dec_en) begin
          cnt_d = cnt_dec;
        end
      end
      S_SPIN: begin
        if (done) begin
          state_d = S_DONE;
        end else if (dec_en) begin
          cnt_d = cnt_dec;
        end
      end
      S_DONE: begin
        if (!done) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = 1'b0;
        code_d  = CODE_NONE;
      end
    endcase
  end

  always_comb begin
    cycle_timeout = (state_q == S_WASH) && (cnt_q == '0);
    spin_timeout  = (state_q == S_SPIN) && (cnt_q == '0);
    fault         = (state_q == S_FAULT);
    fault_code    = code_q;
    remaining     = cnt_q;
    busy          = (state_q != S_IDLE) && (state_q != S_FAULT);
  end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Scoreboard-driven bench for wash_cycle_timer: expected tick counts are queued
// when a phase starts and popped when the corresponding DUT event appears.
module tb_wash_cycle_timer;
  logic       clk = 1'b0;
  logic       reset, tick, fill_value_on, motor_on, drain_value_on, drained, done;
  logic       pause, fault_clear;
  logic [1:0] program_sel;
  logic       cycle_timeout, spin_timeout, fault, busy;
  logic [1:0] fault_code;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;
  int fault_cycles = 0;

  typedef struct {
    string name;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  wash_cycle_timer #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .program_sel(program_sel),
    .fill_value_on(fill_value_on), .motor_on(motor_on), .drain_value_on(drain_value_on),
    .drained(drained), .done(done), .pause(pause), .fault_clear(fault_clear),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .fault(fault),
    .fault_code(fault_code), .remaining(remaining), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (fault === 1'b1) fault_cycles++;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; fill_value_on = 0; motor_on = 0; drain_value_on = 0; drained = 0;
    done = 0; pause = 0; fault_clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    cyc();
  endtask

  task automatic pulse_fill();    fill_value_on = 1;  cyc(); fill_value_on = 0;  endtask
  task automatic pulse_motor();   motor_on = 1;       cyc(); motor_on = 0;       endtask
  task automatic pulse_drain();   drain_value_on = 1; cyc(); drain_value_on = 0; endtask
  task automatic pulse_drained(); drained = 1;        cyc(); drained = 0;        endtask

  // One tick every four clocks.
  task automatic tick_period();
    tick = 1; cyc(); tick = 0;
    repeat (3) cyc();
  endtask

  // Returns the tick number on whose clock the selected timeout appeared, -1 if none.
  task automatic tick_until(input bit spin, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick = 1; cyc(); tick = 0;
      if ((spin ? spin_timeout : cycle_timeout) === 1'b1) begin n = i; break; end
      repeat (3) cyc();
    end
  endtask

  task automatic ticks_to_fault(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick_period();
      if (fault === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    program_sel = 2'b11;
    reset = 1;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    checks++; if ({cycle_timeout, spin_timeout, fault, fault_code} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {cycle_timeout, spin_timeout, fault, fault_code}); end
    reset = 0;
    cyc();
    checks++; if ({busy, cycle_timeout, spin_timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_release: got %b want 000", {busy, cycle_timeout, spin_timeout}); end
    e.name = "unused"; e.val = 0;
  endtask

  task automatic test_normal();
    int n, fc0;
    exp_t e;
    do_reset();
    fc0 = fault_cycles;
    program_sel = 2'b01;
    exp_q.push_back('{"normal_wash1", 20});
    exp_q.push_back('{"normal_wash2", 20});
    exp_q.push_back('{"normal_spin", 10});
    pulse_fill();
    checks++; if (remaining !== 8'd30 || busy !== 1'b1) begin
      errors++; $display("FAIL normal_fill: rem=%0d busy=%b want 30/1", remaining, busy); end
    pulse_motor();
    checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL normal_wash_load: got %0d want 20", remaining); end
    tick_until(0, 60, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    cyc();
    checks++; if (cycle_timeout !== 1'b1) begin errors++; $display("FAIL normal_timeout_level: got %b want 1", cycle_timeout); end
    pulse_drain();
    checks++; if (remaining !== 8'd20 || cycle_timeout !== 1'b0) begin
      errors++; $display("FAIL normal_drain1: rem=%0d ct=%b want 20/0", remaining, cycle_timeout); end
    pulse_drained();
    checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL normal_drained_pass0: got %0d want 20", remaining); end
    pulse_fill();
    checks++; if (remaining !== 8'd30) begin errors++; $display("FAIL normal_refill: got %0d want 30", remaining); end
    pulse_motor();
    tick_until(0, 60, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    pulse_drain();
    pulse_drained();
    checks++; if (remaining !== 8'd10) begin errors++; $display("FAIL normal_spin_load: got %0d want 10", remaining); end
    tick_until(1, 40, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    done = 1; cyc();
    checks++; if (spin_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL normal_done: st=%b busy=%b want 0/1", spin_timeout, busy); end
    done = 0; cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_idle: busy=%b want 0", busy); end
    checks++; if (fault_cycles !== fc0) begin errors++; $display("FAIL normal_no_fault: fault cycles=%0d want 0", fault_cycles - fc0); end
  endtask

  task automatic test_pause();
    int n;
    exp_t e;
    do_reset();
    program_sel = 2'b00;
    exp_q.push_back('{"pause_delay", 13});
    pulse_fill();
    pulse_motor();
    repeat (3) tick_period();
    checks++; if (remaining !== 8'd5) begin errors++; $display("FAIL pause_pre: got %0d want 5", remaining); end
    pause = 1;
    repeat (5) tick_period();
    checks++; if (remaining !== 8'd5 || cycle_timeout !== 1'b0) begin
      errors++; $display("FAIL pause_frozen: rem=%0d ct=%b want 5/0", remaining, cycle_timeout); end
    pause = 0;
    tick_until(0, 30, n);
    e = exp_q.pop_front();
    checks++; if (n + 8 !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n + 8, e.val); end
  endtask

  task automatic test_fill_watchdog();
    int n;
    exp_t e;
    do_reset();
    program_sel = 2'b01;
    exp_q.push_back('{"fill_watchdog", 30});
    fill_value_on = 1;
    cyc();
    ticks_to_fault(40, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    repeat (5) cyc();
    checks++; if ({fault, fault_code, busy} !== 4'b1010) begin
      errors++; $display("FAIL fill_fault_state: got %b want 1010", {fault, fault_code, busy}); end
    fill_value_on = 0;
    fault_clear = 1; cyc(); fault_clear = 0;
    checks++; if ({fault, fault_code, busy} !== 4'b0000) begin
      errors++; $display("FAIL fill_fault_clear: got %b want 0000", {fault, fault_code, busy}); end
  endtask

  task automatic test_drain_watchdog();
    int n;
    exp_t e;
    do_reset();
    program_sel = 2'b11;
    exp_q.push_back('{"drain_watchdog", 20});
    pulse_fill();
    pulse_motor();
    pulse_drain();
    ticks_to_fault(40, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    checks++; if ({fault, fault_code, cycle_timeout, spin_timeout} !== 5'b11000) begin
      errors++; $display("FAIL drain_fault_state: got %b want 11000", {fault, fault_code, cycle_timeout, spin_timeout}); end
    fault_clear = 1; cyc(); fault_clear = 0;
    checks++; if (fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL drain_fault_clear: fault=%b code=%b want 0/00", fault, fault_code); end
  endtask

  task automatic test_edges();
    int n;
    exp_t e;
    do_reset();
    program_sel = 2'b10;
    exp_q.push_back('{"heavy_wash", 40});
    pulse_fill();
    motor_on = 1; tick = 1; cyc(); motor_on = 0; tick = 0;
    checks++; if (remaining !== 8'd40) begin errors++; $display("FAIL edge_tick_on_load: got %0d want 40", remaining); end
    program_sel = 2'b00;
    tick_until(0, 60, n);
    e = exp_q.pop_front();
    checks++; if (n !== e.val) begin errors++; $display("FAIL %s: ticks=%0d want %0d", e.name, n, e.val); end
    pause = 1;
    pulse_drain();
    checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL edge_pause_reload: got %0d want 20", remaining); end
    pause = 0;
    pulse_fill();
    pulse_motor();
    checks++; if (remaining !== 8'd40) begin errors++; $display("FAIL edge_prog_latched_wash: got %0d want 40", remaining); end
    pulse_drain();
    pulse_drained();
    checks++; if (remaining !== 8'd16) begin errors++; $display("FAIL edge_prog_latched_spin: got %0d want 16", remaining); end
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    program_sel = 2'b01;
    pulse_fill(); pulse_motor(); pulse_drain();
    pulse_fill(); pulse_motor(); pulse_drain(); pulse_drained();
    repeat (7) begin tick = 1; cyc(); tick = 0; cyc(); end
    checks++; if (remaining !== 8'd3) begin errors++; $display("FAIL spin_pre_reset: got %0d want 3", remaining); end
    #2 reset = 1;
    #1;
    checks++; if ({busy, cycle_timeout, spin_timeout, fault, fault_code} !== 6'b0 || remaining !== 8'd0) begin
      errors++; $display("FAIL async_reset: flags=%b rem=%0d want 0/0", {busy, cycle_timeout, spin_timeout, fault, fault_code}, remaining); end
    cyc();
    #2 reset = 0;
    cyc();
    checks++; if (busy !== 1'b0 || spin_timeout !== 1'b0 || remaining !== 8'd0) begin
      errors++; $display("FAIL post_reset: busy=%b st=%b rem=%0d want 0/0/0", busy, spin_timeout, remaining); end
    pulse_fill();
    checks++; if (remaining !== 8'd30) begin errors++; $display("FAIL post_reset_idle: got %0d want 30", remaining); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_pause();
    test_fill_watchdog();
    test_drain_watchdog();
    test_edges();
    test_reset_mid_spin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_timer.md
WASH_CYCLE_TIMER -- requirements
Module: wash_cycle_timer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port tick  input  1  one-cycle time-base enable; all durations are counted in qualifying ticks.
REQ-004 SHALL have port program  input  2  wash program: 00 quick, 01 normal, 10 heavy, 11 delicate.
REQ-005 SHALL have ports fill_value_on, motor_on, drain_value_on, drained, done  input  1 each  washer valve, motor and status signals being timed.
REQ-006 SHALL have port pause  input  1  freezes all counting while high.
REQ-007 SHALL have port fault_clear  input  1  leaves FAULT.
REQ-008 SHALL have port cycle_timeout  output  1  wash period expired; drives the washer cycle_timeout input.
REQ-009 SHALL have port spin_timeout  output  1  spin period expired; drives the washer spin_timeout input.
REQ-010 SHALL have ports fault  output  1  and fault_code  output  2  (01 fill watchdog, 10 drain watchdog, 00 none).
REQ-011 SHALL have port remaining  output  8  current down-counter value.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE and FAULT.

Function
REQ-013 SHALL implement states IDLE, FILL, WASH, DRAIN, SPIN, DONE, FAULT, with one transition per clock at most.
REQ-014 SHALL make the following transitions:
- IDLE->FILL on fill_value_on=1; program is latched at this edge.
- FILL->WASH on motor_on=1.
- WASH->DRAIN on drain_value_on=1.
- DRAIN->FILL on fill_value_on=1 when pass=0; pass is set to 1 at this edge.
- DRAIN->SPIN on drained=1 when pass=1.
- SPIN->DONE on done=1.
- DONE->IDLE on done=0; pass is cleared at this edge.
REQ-015 SHALL load the counter on each transition: wash ticks on entry to WASH, spin ticks on entry to SPIN, 30 on entry to FILL, 20 on entry to DRAIN.
REQ-016 SHALL use these wash/spin tick counts per program: quick 8/4, normal 20/10, heavy 40/16, delicate 12/2.
REQ-017 SHALL count as follows: in any counting state, when tick=1, pause=0 and counter≠0, decrement by 1; hold at 0; never wrap.
REQ-018 SHALL generate outputs combinationally:
- cycle_timeout = (state==WASH && counter==0).
- spin_timeout = (state==SPIN && counter==0).
- Both are levels, held until the state is left.
REQ-019 SHALL give a latency of 1 clock from the cycle with the Nth qualifying tick to the timeout asserting.
REQ-020 SHALL enter FAULT from FILL or DRAIN when the counter is 0 and no exit condition is true in that cycle:
- From FILL: fault_code=01.
- From DRAIN: fault_code=10.
REQ-021 SHALL make FAULT sticky: fault=1 and both timeouts 0 until fault_clear=1, then go to IDLE with fault=0, fault_code=00 and pass=0.
REQ-022 SHALL give a transition condition priority over a tick in the same cycle: the counter reloads and does not decrement.
REQ-023 SHALL let transitions proceed while pause=1 (counter still reloads); only decrementing and watchdog expiry are frozen.
REQ-024 SHALL ignore a program change after IDLE->FILL until the next IDLE->FILL.
REQ-025 SHALL ignore unlisted input combinations in each state (state held).
REQ-026 SHALL use 3-bit state encoding; any illegal encoding recovers to IDLE on the next clock.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, counter=0, pass=0, latched program=00, cycle_timeout=0, spin_timeout=0, fault=0, fault_code=00, busy=0, asynchronously and including mid-cycle.
REQ-028 SHALL make reset deassertion take effect on the next rising clk, with no spurious timeout pulse.

Verification
REQ-029 Normal run: program=01, full two-pass sequence, tick every 4 clocks -> cycle_timeout high after the 20th tick of each WASH; spin_timeout high after the 10th SPIN tick; DONE->IDLE; fault=0 throughout.
REQ-030 Pause: program=00, pause=1 for 5 ticks mid-WASH -> remaining is frozen; cycle_timeout is delayed by exactly those 5 ticks.
REQ-031 Fill watchdog: fill_value_on=1 with motor_on held 0 for 30 ticks -> FAULT, fault_code=01, busy=0; fault_clear -> IDLE.
REQ-032 Drain watchdog: in DRAIN, drained=0 and fill_value_on=0 for 20 ticks -> fault_code=10; the timeouts stay 0.
REQ-033 Edge cases:
- tick coincident with FILL->WASH -> remaining equals the loaded wash value, not value minus 1.
- program changed during WASH -> no effect.
REQ-034 Reset mid-SPIN with counter=3 -> all outputs 0 immediately, remaining=0, state IDLE after reset release.
